// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared 8b/10b PHY constants, state encoding and comma helper
package phy_pkg;

  localparam int SYMBOL_W = 10;

  localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic logic is_k28_5(input logic [SYMBOL_W-1:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/serial_word_aligner_if.sv
// rtl/serial_word_aligner_if.sv - serial bit in, aligned symbol stream out
interface serial_word_aligner_if;
  import phy_pkg::*;

  logic                serial_in;
  logic [SYMBOL_W-1:0] symbol_out;
  logic                symbol_valid;
  logic                is_comma;
  logic                locked;

  // master is the aligner itself; slave is whoever feeds bits and takes symbols
  modport master (
    input  serial_in,
    output symbol_out,
    output symbol_valid,
    output is_comma,
    output locked
  );

  modport slave (
    output serial_in,
    input  symbol_out,
    input  symbol_valid,
    input  is_comma,
    input  locked
  );

endinterface

// File: rtl/comma_detect.sv
// rtl/comma_detect.sv - combinational K28.5 match in either running disparity
module comma_detect
  import phy_pkg::*;
(
  input  logic [SYMBOL_W-1:0] sym,
  output logic                match
);

  assign match = is_k28_5(sym);

endmodule

// File: rtl/serial_word_aligner.sv
// rtl/serial_word_aligner.sv - comma hunt, symbol boundary lock and aligned symbol output
module serial_word_aligner
  import phy_pkg::*;
#(
  parameter int LOCK_COMMAS   = 3,
  parameter int COMMA_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_aligner_if.master sw
);

  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int TW = $clog2(COMMA_TIMEOUT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COMMAS);
  localparam logic [TW-1:0] TO_MAX   = TW'(COMMA_TIMEOUT);

  logic [SYMBOL_W-1:0] sr;
  logic [SYMBOL_W-1:0] nsr;
  logic                comma;
  logic                boundary;

  align_state_t state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0] good_cnt, good_cnt_n, good_inc;
  logic [TW-1:0] to_cnt, to_cnt_n, to_inc;
  logic          emit;

  logic [SYMBOL_W-1:0] sym_q;
  logic                valid_q;
  logic                comma_q;

  // Detection looks at the register value after this edge's shift.
  assign nsr      = {sw.serial_in, sr[SYMBOL_W-1:1]};
  assign boundary = (bit_cnt == 4'd9);
  assign good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
  assign to_inc   = to_cnt + 1'b1;

  comma_detect u_comma_detect (
    .sym   (nsr),
    .match (comma)
  );

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    good_cnt_n = good_cnt;
    to_cnt_n   = to_cnt;
    emit       = 1'b0;

    case (state)
      HUNT: begin
        if (comma) begin
          emit       = 1'b1;
          bit_cnt_n  = 4'd0;
          good_cnt_n = GW'(1);
          to_cnt_n   = '0;
          state_n    = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
        end
      end

      VERIFY, LOCKED: begin
        if (boundary) begin
          emit      = 1'b1;
          bit_cnt_n = 4'd0;
          if (comma) begin
            to_cnt_n   = '0;
            good_cnt_n = good_inc;
            if (state == VERIFY && good_inc == GOOD_MAX) begin
              state_n = LOCKED;
            end
          end else begin
            to_cnt_n = to_inc;
            if (to_inc == TO_MAX) begin
              state_n = HUNT;
            end
          end
        end else if (comma) begin
          // Comma off the current boundary: trust the new one and re-verify.
          emit       = 1'b1;
          bit_cnt_n  = 4'd0;
          good_cnt_n = GW'(1);
          to_cnt_n   = '0;
          state_n    = VERIFY;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end

      default: begin
        state_n = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      state    <= HUNT;
      bit_cnt  <= 4'd0;
      good_cnt <= '0;
      to_cnt   <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
    end else begin
      sr       <= nsr;
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      good_cnt <= good_cnt_n;
      to_cnt   <= to_cnt_n;
      valid_q  <= emit;
      comma_q  <= emit && comma;
      if (emit) begin
        sym_q <= nsr;
      end
    end
  end

  assign sw.symbol_out   = sym_q;
  assign sw.symbol_valid = valid_q;
  assign sw.is_comma     = comma_q;
  assign sw.locked       = (state == LOCKED);

endmodule
